// File: rtl/gpr_wb_arb.sv
// Writeback arbiter: two buffered producer channels drive the two register-file write ports.
// Define GPR_WB_SCOREBOARD_EN to generate the pending-write `busy` vector (otherwise tied to zero).
module gpr_wb_arb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_val,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_val,
    output logic        write_a_en,
    output logic [4:0]  write_a_select,
    output logic [31:0] write_a_val,
    output logic        write_b_en,
    output logic [4:0]  write_b_select,
    output logic [31:0] write_b_val,
    output logic [31:0] busy,
    output logic        idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    aMemReg_q [DEPTH];
    logic [31:0]   aMemVal_q [DEPTH];
    logic [PW-1:0] aWr_q, aRd_q;
    logic [CW-1:0] aCount_q;
    logic [4:0]    bMemReg_q [DEPTH];
    logic [31:0]   bMemVal_q [DEPTH];
    logic [PW-1:0] bWr_q, bRd_q;
    logic [CW-1:0] bCount_q;

    logic        aEn_q, bEn_q;
    logic [4:0]  aSel_q, bSel_q;
    logic [31:0] aVal_q, bVal_q;
    logic        prioB_q, prioB_d;
    logic        outOfReset_q;

    logic        aPush, bPush, aPresent, bPresent, conflict, aIssue, bIssue;
    logic [4:0]  aHeadReg, bHeadReg;
    logic [31:0] aHeadVal, bHeadVal;

    assign a_ready = outOfReset_q && (aCount_q != CW'(DEPTH));
    assign b_ready = outOfReset_q && (bCount_q != CW'(DEPTH));
    assign aPush   = a_valid && a_ready;
    assign bPush   = b_valid && b_ready;

    // On a same-register collision the loser holds exactly one cycle; prioB alternates the winner.
    always_comb begin
        aHeadReg = aMemReg_q[aRd_q];
        aHeadVal = aMemVal_q[aRd_q];
        bHeadReg = bMemReg_q[bRd_q];
        bHeadVal = bMemVal_q[bRd_q];
        aPresent = (aCount_q != '0);
        bPresent = (bCount_q != '0);
        conflict = aPresent && bPresent && (aHeadReg == bHeadReg);
        aIssue   = aPresent && !(conflict && prioB_q);
        bIssue   = bPresent && !(conflict && !prioB_q);
        prioB_d  = conflict && !prioB_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                aMemReg_q[i] <= '0;
                aMemVal_q[i] <= '0;
                bMemReg_q[i] <= '0;
                bMemVal_q[i] <= '0;
            end
            aWr_q        <= '0;
            aRd_q        <= '0;
            aCount_q     <= '0;
            bWr_q        <= '0;
            bRd_q        <= '0;
            bCount_q     <= '0;
            aEn_q        <= 1'b0;
            bEn_q        <= 1'b0;
            aSel_q       <= '0;
            bSel_q       <= '0;
            aVal_q       <= '0;
            bVal_q       <= '0;
            prioB_q      <= 1'b0;
            outOfReset_q <= 1'b0;
        end else begin
            outOfReset_q <= 1'b1;
            prioB_q      <= prioB_d;

            if (aPush) begin
                aMemReg_q[aWr_q] <= a_reg;
                aMemVal_q[aWr_q] <= a_val;
                aWr_q            <= aWr_q + PW'(1);
            end
            if (bPush) begin
                bMemReg_q[bWr_q] <= b_reg;
                bMemVal_q[bWr_q] <= b_val;
                bWr_q            <= bWr_q + PW'(1);
            end
            aCount_q <= aCount_q + CW'(aPush) - CW'(aIssue);
            bCount_q <= bCount_q + CW'(bPush) - CW'(bIssue);

            // Select and value are kept when a port is not reloaded; only the enable drops.
            aEn_q <= aIssue;
            if (aIssue) begin
                aSel_q <= aHeadReg;
                aVal_q <= aHeadVal;
                aRd_q  <= aRd_q + PW'(1);
            end
            bEn_q <= bIssue;
            if (bIssue) begin
                bSel_q <= bHeadReg;
                bVal_q <= bHeadVal;
                bRd_q  <= bRd_q + PW'(1);
            end
        end
    end

    assign write_a_en     = aEn_q;
    assign write_a_select = aSel_q;
    assign write_a_val    = aVal_q;
    assign write_b_en     = bEn_q;
    assign write_b_select = bSel_q;
    assign write_b_val    = bVal_q;
    assign idle = (aCount_q == '0) && (bCount_q == '0) && !aEn_q && !bEn_q;

`ifdef GPR_WB_SCOREBOARD_EN
    logic [31:0]   busyVec;
    logic [PW-1:0] aOff, bOff;

    // An entry slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        busyVec = '0;
        aOff    = '0;
        bOff    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            aOff = PW'(i) - aRd_q;
            bOff = PW'(i) - bRd_q;
            if ({1'b0, aOff} < aCount_q) busyVec[aMemReg_q[i]] = 1'b1;
            if ({1'b0, bOff} < bCount_q) busyVec[bMemReg_q[i]] = 1'b1;
        end
        if (aEn_q) busyVec[aSel_q] = 1'b1;
        if (bEn_q) busyVec[bSel_q] = 1'b1;
    end

    assign busy = busyVec;
`else
    assign busy = 32'h0;
`endif

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Directed bench for gpr_wb_arb: per-port expected-write queues filled at handshake,
// drained as the register-file ports fire.
module tb_gpr_wb_arb;

    localparam int DEPTH = 2;
`ifdef GPR_WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_val, b_val;
    logic        write_a_en, write_b_en;
    logic [4:0]  write_a_select, write_b_select;
    logic [31:0] write_a_val, write_b_val;
    logic [31:0] busy;
    logic        idle;

    gpr_wb_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_val(a_val),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_val(b_val),
        .write_a_en(write_a_en), .write_a_select(write_a_select), .write_a_val(write_a_val),
        .write_b_en(write_b_en), .write_b_select(write_b_select), .write_b_val(write_b_val),
        .busy(busy), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] v;
    } wr_t;

    wr_t expA[$];
    wr_t expB[$];
    int  testsRun = 0;
    int  failCount = 0;
    int  writesA = 0, writesB = 0;
    int  gapA = 0, gapB = 0, maxGapA = 0, maxGapB = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus from negedge+2, record handshakes, return at the next negedge+2.
    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] br, input logic [31:0] bd,
                                 output bit aAcc, output bit bAcc);
        wr_t e;
        a_valid = av; a_reg = ar; a_val = ad;
        b_valid = bv; b_reg = br; b_val = bd;
        #1;
        aAcc = av && a_ready;
        bAcc = bv && b_ready;
        if (aAcc) begin e.r = ar; e.v = ad; expA.push_back(e); end
        if (bAcc) begin e.r = br; e.v = bd; expB.push_back(e); end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        #2;
    endtask

    // Port monitor: every issued write must match the head of its channel's expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (expA.size() != 0 && !write_a_en) gapA++; else gapA = 0;
        if (expB.size() != 0 && !write_b_en) gapB++; else gapB = 0;
        if (gapA > maxGapA) maxGapA = gapA;
        if (gapB > maxGapB) maxGapB = gapB;
        if (write_a_en && write_b_en)
            checkOutput("port select clash", 32'(write_a_select == write_b_select), 32'd0);
        if (write_a_en) begin
            writesA++;
            checkOutput("A write expected", 32'(expA.size() != 0), 32'd1);
            if (expA.size() != 0) begin
                e = expA.pop_front();
                checkOutput("A select", 32'(write_a_select), 32'(e.r));
                checkOutput("A value", write_a_val, e.v);
            end
        end
        if (write_b_en) begin
            writesB++;
            checkOutput("B write expected", 32'(expB.size() != 0), 32'd1);
            if (expB.size() != 0) begin
                e = expB.pop_front();
                checkOutput("B select", 32'(write_b_select), 32'(e.r));
                checkOutput("B value", write_b_val, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit aAcc, bAcc, sawNotReady;
        int ia, ib, pushA, baseWA;

        reset = 1'b0;
        a_valid = 1'b0; a_reg = '0; a_val = '0;
        b_valid = 1'b0; b_reg = '0; b_val = '0;
        #2;
        checkOutput("reset write_a_en", 32'(write_a_en), 32'd0);
        checkOutput("reset write_b_en", 32'(write_b_en), 32'd0);
        checkOutput("reset a select", 32'(write_a_select), 32'd0);
        checkOutput("reset b value", write_b_val, 32'd0);
        checkOutput("reset busy", busy, 32'd0);
        checkOutput("reset idle", 32'(idle), 32'd1);
        checkOutput("reset a_ready", 32'(a_ready), 32'd0);
        @(negedge clk); #2;
        checkOutput("reset b_ready after edge", 32'(b_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk); #2;
        checkOutput("a_ready after release", 32'(a_ready), 32'd1);
        checkOutput("b_ready after release", 32'(b_ready), 32'd1);

        // Single write
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, aAcc, bAcc);
        checkOutput("sw accepted", 32'(aAcc), 32'd1);
        checkOutput("sw c0 write_a_en", 32'(write_a_en), 32'd0);
        checkOutput("sw c0 idle", 32'(idle), 32'd0);
        checkOutput("sw c0 busy", busy, SB_EN ? 32'h20 : 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, aAcc, bAcc);
        checkOutput("sw c1 write_a_en", 32'(write_a_en), 32'd1);
        checkOutput("sw c1 select", 32'(write_a_select), 32'd5);
        checkOutput("sw c1 value", write_a_val, 32'hDEADBEEF);
        checkOutput("sw c1 write_b_en", 32'(write_b_en), 32'd0);
        checkOutput("sw c1 busy", busy, SB_EN ? 32'h20 : 32'h0);
        checkOutput("sw c1 idle", 32'(idle), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, aAcc, bAcc);
        checkOutput("sw c2 write_a_en", 32'(write_a_en), 32'd0);
        checkOutput("sw c2 busy", busy, 32'h0);
        checkOutput("sw c2 idle", 32'(idle), 32'd1);

        // Parallel writes to distinct registers
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, aAcc, bAcc);
        checkOutput("par c0 busy", busy, SB_EN ? 32'h18 : 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, aAcc, bAcc);
        checkOutput("par c1 write_a_en", 32'(write_a_en), 32'd1);
        checkOutput("par c1 write_b_en", 32'(write_b_en), 32'd1);
        checkOutput("par c1 b select", 32'(write_b_select), 32'd4);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, aAcc, bAcc);
        checkOutput("par c2 idle", 32'(idle), 32'd1);

        // Single conflict on register 7
        applyStimulus(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, aAcc, bAcc);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, aAcc, bAcc);
        checkOutput("cf c1 write_a_en", 32'(write_a_en), 32'd1);
        checkOutput("cf c1 a value", write_a_val, 32'hA);
        checkOutput("cf c1 write_b_en", 32'(write_b_en), 32'd0);
        checkOutput("cf c1 busy", busy, SB_EN ? 32'h80 : 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, aAcc, bAcc);
        checkOutput("cf c2 write_b_en", 32'(write_b_en), 32'd1);
        checkOutput("cf c2 b select", 32'(write_b_select), 32'd7);
        checkOutput("cf c2 b value", write_b_val, 32'hB);
        checkOutput("cf c2 write_a_en", 32'(write_a_en), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, aAcc, bAcc);
        checkOutput("cf c3 idle", 32'(idle), 32'd1);

        // Continuous conflicts with backpressure: every entry on both channels targets reg 20
        ia = 0; ib = 0; pushA = 0; baseWA = writesA; sawNotReady = 1'b0;
        for (int cyc = 0; cyc < 40 && (ia < 4 || ib < 4); cyc++) begin
            checkOutput("bp a_ready", 32'(a_ready), 32'((pushA - (writesA - baseWA)) < DEPTH));
            if (!a_ready) sawNotReady = 1'b1;
            applyStimulus(ia < 4, 5'd20, 32'hA00 + 32'(ia), ib < 4, 5'd20, 32'hB00 + 32'(ib), aAcc, bAcc);
            if (aAcc) begin ia++; pushA++; end
            if (bAcc) ib++;
        end
        checkOutput("bp all A accepted", 32'(ia), 32'd4);
        checkOutput("bp all B accepted", 32'(ib), 32'd4);
        checkOutput("bp a_ready dropped", 32'(sawNotReady), 32'd1);
        for (int cyc = 0; cyc < 20 && (expA.size() != 0 || expB.size() != 0); cyc++)
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, aAcc, bAcc);
        checkOutput("bp A drained", 32'(expA.size()), 32'd0);
        checkOutput("bp B drained", 32'(expB.size()), 32'd0);
        checkOutput("A max stall bound", 32'(maxGapA <= 2), 32'd1);
        checkOutput("B max stall bound", 32'(maxGapB <= 2), 32'd1);

        // Reset mid-stream with work queued in both FIFOs and output registers
        applyStimulus(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h201, aAcc, bAcc);
        applyStimulus(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h204, aAcc, bAcc);
        checkOutput("rst pre write_a_en", 32'(write_a_en), 32'd1);
        reset = 1'b0;
        expA.delete();
        expB.delete();
        #1;
        checkOutput("rst write_a_en", 32'(write_a_en), 32'd0);
        checkOutput("rst write_b_en", 32'(write_b_en), 32'd0);
        checkOutput("rst busy", busy, 32'h0);
        checkOutput("rst idle", 32'(idle), 32'd1);
        checkOutput("rst a_ready", 32'(a_ready), 32'd0);
        @(negedge clk); #2;
        checkOutput("rst b_ready held", 32'(b_ready), 32'd0);
        reset = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, aAcc, bAcc);
            checkOutput("post-rst write_a_en", 32'(write_a_en), 32'd0);
            checkOutput("post-rst write_b_en", 32'(write_b_en), 32'd0);
        end
        checkOutput("post-rst idle", 32'(idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
